// File: rtl/vfirst_m.sv
// vfirst.m mask-to-index reduction: lowest active set mask bit across beats, or -1.
// Optional VFIRST_CPOP_EN adds vcpop.m (in_op=1) using a per-op popcount accumulator.
module vfirst_m #(
  parameter int unsigned REQ_DATA_WIDTH  = 64,
  parameter int unsigned RESP_DATA_WIDTH = 64,
  parameter int unsigned REQ_ADDR_WIDTH  = 5,
  parameter int unsigned IDX_WIDTH       = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [REQ_DATA_WIDTH-1:0]  in_vec,
  input  logic [IDX_WIDTH-1:0]       in_start_idx,
  input  logic [IDX_WIDTH:0]         in_vl,
  input  logic                       in_last,
  input  logic                       in_op,
  input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
  output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
  output logic [RESP_DATA_WIDTH-1:0] out_vec,
  output logic                       out_valid
);

  localparam int unsigned POS_W = $clog2(REQ_DATA_WIDTH);
  localparam int unsigned CNT_W = IDX_WIDTH + 1;

  typedef enum logic {ACC_IDLE, ACC_FOUND} acc_state_t;

  logic [REQ_DATA_WIDTH-1:0] act;
  logic [REQ_DATA_WIDTH-1:0] hits;
  logic [POS_W-1:0]          hit_pos;

  // Element k is active when start+k < vl, compared one bit wider than the index.
  always_comb begin
    act     = '0;
    hit_pos = '0;
    for (int unsigned k = 0; k < REQ_DATA_WIDTH; k++)
      act[k] = ({1'b0, in_start_idx} + CNT_W'(k)) < in_vl;
    hits = in_vec & act;
    for (int unsigned k = REQ_DATA_WIDTH; k > 0; k--)
      if (hits[k-1]) hit_pos = POS_W'(k-1);
  end

  logic                      a_valid;
  logic                      a_hit;
  logic [POS_W-1:0]          a_pos;
  logic [IDX_WIDTH-1:0]      a_start;
  logic                      a_last;
  logic [REQ_ADDR_WIDTH-1:0] a_addr;

  always_ff @(posedge clk) begin
    if (rst) a_valid <= 1'b0;
    else     a_valid <= in_valid;
    a_hit   <= |hits;
    a_pos   <= hit_pos;
    a_start <= in_start_idx;
    a_last  <= in_last;
    a_addr  <= in_addr;
  end

`ifdef VFIRST_CPOP_EN
  logic [POS_W:0] hit_cnt;
  logic [POS_W:0] a_cnt;
  logic           a_op;
  logic [CNT_W-1:0] cnt_acc;
  logic [CNT_W-1:0] cnt_sum;

  always_comb begin
    hit_cnt = '0;
    for (int unsigned k = 0; k < REQ_DATA_WIDTH; k++)
      hit_cnt = hit_cnt + (POS_W+1)'(hits[k]);
  end

  always_ff @(posedge clk) begin
    a_cnt <= hit_cnt;
    a_op  <= in_op;
  end

  assign cnt_sum = cnt_acc + CNT_W'(a_cnt);
`else
  logic unused_op;
  assign unused_op = in_op;
`endif

  acc_state_t           acc_state;
  logic [IDX_WIDTH-1:0] found_idx;
  logic                 m_found;
  logic [IDX_WIDTH-1:0] m_idx;

  // Merge the accumulator with the beat in stage A so the last beat's own hit counts.
  always_comb begin
    m_found = (acc_state == ACC_FOUND) || a_hit;
    m_idx   = (acc_state == ACC_FOUND) ? found_idx : (a_start + IDX_WIDTH'(a_pos));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_state <= ACC_IDLE;
      found_idx <= '0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_addr  <= '0;
`ifdef VFIRST_CPOP_EN
      cnt_acc   <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (a_valid) begin
        if (a_last) begin
          out_valid <= 1'b1;
          out_addr  <= a_addr;
          out_vec   <= m_found ? RESP_DATA_WIDTH'(m_idx) : '1;
          acc_state <= ACC_IDLE;
`ifdef VFIRST_CPOP_EN
          if (a_op) out_vec <= RESP_DATA_WIDTH'(cnt_sum);
          cnt_acc <= '0;
`endif
        end else begin
          if (m_found) begin
            acc_state <= ACC_FOUND;
            found_idx <= m_idx;
          end
`ifdef VFIRST_CPOP_EN
          cnt_acc <= cnt_sum;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_vfirst_m.sv
// Directed table-driven bench for vfirst_m, plus multi-beat / back-to-back / reset sequences.
module tb_vfirst_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_vec;
  logic [11:0] in_start_idx;
  logic [12:0] in_vl;
  logic        in_last;
  logic        in_op;
  logic [4:0]  in_addr;
  logic [4:0]  out_addr;
  logic [63:0] out_vec;
  logic        out_valid;

  localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

  int checks = 0;
  int errors = 0;

  vfirst_m #(
    .REQ_DATA_WIDTH(64), .RESP_DATA_WIDTH(64), .REQ_ADDR_WIDTH(5), .IDX_WIDTH(12)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec),
    .in_start_idx(in_start_idx), .in_vl(in_vl), .in_last(in_last), .in_op(in_op),
    .in_addr(in_addr), .out_addr(out_addr), .out_vec(out_vec), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] vec;
    logic [11:0] start;
    logic [12:0] vl;
    logic [4:0]  addr;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_vec   = '0;
  endtask

  task automatic drive(input logic [63:0] v, input logic [11:0] s, input logic [12:0] vl,
                       input logic last, input logic [4:0] a, input logic op);
    in_valid     = 1'b1;
    in_vec       = v;
    in_start_idx = s;
    in_vl        = vl;
    in_last      = last;
    in_addr      = a;
    in_op        = op;
    step();
  endtask

  task automatic chk_out(input string name, input logic [63:0] ev, input logic [4:0] ea);
    chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({name, "_vec"}, out_vec, ev);
    chk({name, "_addr"}, {59'd0, out_addr}, {59'd0, ea});
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {63'd0, out_valid}, 64'd0);
  endtask

  logic [63:0] cpop_exp1, cpop_exp2;

  initial begin
    tbl[0] = '{"bit8",      64'h0000_0000_0000_0100, 12'd0,    13'd64,   5'd3,  64'd8};
    tbl[1] = '{"vl40_hi",   64'hFFFF_0000_0000_0000, 12'd0,    13'd40,   5'd4,  NEG1};
    tbl[2] = '{"vl0",       NEG1,                    12'd0,    13'd0,    5'd5,  NEG1};
    tbl[3] = '{"vl_edge_in",64'h0000_0080_0000_0000, 12'd0,    13'd40,   5'd6,  64'd39};
    tbl[4] = '{"vl_edge_out",64'h0000_0100_0000_0000,12'd0,    13'd40,   5'd7,  NEG1};
    tbl[5] = '{"start_ge_vl",NEG1,                   12'd64,   13'd64,   5'd8,  NEG1};
    tbl[6] = '{"max_idx",   64'h8000_0000_0000_0000, 12'd4032, 13'd4096, 5'd31, 64'd4095};
    tbl[7] = '{"lowest",    64'h8000_0000_0000_0001, 12'd128,  13'd256,  5'd9,  64'd128};
    tbl[8] = '{"mid_vl",    64'h0000_0000_0000_0700, 12'd100,  13'd110,  5'd10, 64'd108};

    rst = 1'b1;
    in_start_idx = '0; in_vl = '0; in_addr = '0; in_op = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_vec", out_vec, 64'd0);
    chk("rst_addr", {59'd0, out_addr}, 64'd0);

    // Single-beat ops: result two edges after the beat is presented, one-cycle pulse.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].vec, tbl[i].start, tbl[i].vl, 1'b1, tbl[i].addr, 1'b0);
      idle();
      step();
      chk_out(tbl[i].name, tbl[i].exp, tbl[i].addr);
      step();
      chk_quiet({tbl[i].name, "_pulse"});
    end

    // Four beats; first hit in beat 2 (128+4), beat 3 hit ignored.
    drive(64'h0,  12'd0,   13'd256, 1'b0, 5'd12, 1'b0);
    drive(64'h0,  12'd64,  13'd256, 1'b0, 5'd12, 1'b0);
    chk_quiet("four_mid0");
    drive(64'h10, 12'd128, 13'd256, 1'b0, 5'd12, 1'b0);
    chk_quiet("four_mid1");
    drive(64'h1,  12'd192, 13'd256, 1'b1, 5'd12, 1'b0);
    chk_quiet("four_mid2");
    idle();
    step();
    chk_out("four", 64'd132, 5'd12);
    step();
    chk_quiet("four_pulse");

    // Back-to-back: A (bit5), B (empty), then a third op with a bubble, hit 64+7.
    drive(64'h20, 12'd0, 13'd64, 1'b1, 5'd1, 1'b0);
    drive(64'h0,  12'd0, 13'd64, 1'b1, 5'd2, 1'b0);
    chk_out("b2b_A", 64'd5, 5'd1);
    drive(64'h0,  12'd0, 13'd128, 1'b0, 5'd13, 1'b0);
    chk_out("b2b_B", NEG1, 5'd2);
    idle();
    step();
    chk_quiet("b2b_bubble");
    drive(64'h80, 12'd64, 13'd128, 1'b1, 5'd13, 1'b0);
    chk_quiet("b2b_wait");
    idle();
    step();
    chk_out("b2b_C", 64'd71, 5'd13);

    // Reset mid-op, with a competing last beat in the reset cycle.
    drive(64'h8, 12'd0, 13'd128, 1'b0, 5'd14, 1'b0);
    rst = 1'b1;
    drive(64'h1, 12'd0, 13'd128, 1'b1, 5'd20, 1'b0);
    rst = 1'b0;
    idle();
    chk_quiet("rstmid_q0");
    chk("rstmid_vec0", out_vec, 64'd0);
    step();
    chk_quiet("rstmid_q1");
    drive(64'h0, 12'd64, 13'd128, 1'b1, 5'd15, 1'b0);
    chk_quiet("rstmid_q2");
    idle();
    step();
    chk_out("rstmid", NEG1, 5'd15);

`ifdef VFIRST_CPOP_EN
    cpop_exp1 = 64'd16;
    cpop_exp2 = 64'd2;
`else
    cpop_exp1 = 64'd0;
    cpop_exp2 = 64'd0;
`endif
    drive(64'hFF,   12'd0,  13'd128, 1'b0, 5'd7, 1'b1);
    drive(64'h0F0F, 12'd64, 13'd128, 1'b1, 5'd7, 1'b1);
    drive(64'h3,    12'd0,  13'd128, 1'b1, 5'd11, 1'b1);
    idle();
    chk_out("cpop1", cpop_exp1, 5'd7);
    step();
    chk_out("cpop2", cpop_exp2, 5'd11);
    step();
    chk_quiet("cpop_pulse");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
